if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 175 +++++++++++++++++
 tb/tb_if_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch: PC, 2-entry in-order buffer, redirect flush of in-flight reads.
// Latency: grant -> inst_valid in 2 cycles min. Backpressure: id_ready low holds the head,
// and requests stop once buffered + outstanding reaches 2. Option: IF_JAL_PREDECODE_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, FLUSH = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  stale_q, stale_d;
  logic [1:0]  cnt_q;
  logic [31:0] hd_dat, hd_pc, tl_dat, tl_pc;

  logic        req_fire, pop, ext_redir, int_redir, redir;
  logic        rsp_fresh, rsp_stale;
  logic [31:0] redir_tgt, rsp_pc;

  assign req_fire  = imem_req & imem_gnt;
  assign pop       = inst_valid & id_ready;
  assign ext_redir = redirect_valid & (state_q != BOOT);

`ifdef IF_JAL_PREDECODE_EN
  logic        jal_pop;
  logic [31:0] jal_imm, jal_tgt;

  assign jal_pop   = pop & (hd_dat[6:0] == 7'b1101111);
  assign jal_imm   = {{11{hd_dat[31]}}, hd_dat[31], hd_dat[19:12], hd_dat[20], hd_dat[30:21], 1'b0};
  assign jal_tgt   = hd_pc + jal_imm;
  assign int_redir = jal_pop & (state_q == FETCH) & ~ext_redir;
  assign redir_tgt = ext_redir ? redirect_pc : jal_tgt;
`else
  assign int_redir = 1'b0;
  assign redir_tgt = redirect_pc;
`endif

  assign redir     = ext_redir | int_redir;
  // In FETCH nothing outstanding is stale, so all responses are fresh unless a redirect lands now.
  assign rsp_fresh = imem_rvalid & (state_q == FETCH) & ~redir;
  assign rsp_stale = imem_rvalid & (state_q == FLUSH);
  // Outstanding requests are sequential and in order, so the oldest one sits out_q words behind PC.
  assign rsp_pc    = pc_q - {28'd0, out_q, 2'b00};

  always_comb begin
    stale_d = stale_q;
    if ((state_q == FETCH) && redir) begin
      stale_d = out_q + {1'b0, req_fire} - {1'b0, imem_rvalid};
    end else if (state_q == FLUSH) begin
      stale_d = stale_q - {1'b0, rsp_stale};
    end
  end

  always_comb begin
    out_d = out_q + {1'b0, req_fire} - {1'b0, rsp_fresh};
    if (redir) begin
      out_d = 2'd0;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redir) begin
      pc_d = redir_tgt & 32'hFFFF_FFFC;
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // FSM: state register
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (redir && (stale_d != 2'd0)) state_d = FLUSH;
      FLUSH:   if (stale_d == 2'd0) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    imem_req = 1'b0;
    if ((state_q == FETCH) && (({1'b0, out_q} + {1'b0, cnt_q}) < 3'd2)) begin
      imem_req = 1'b1;
    end
  end

  assign imem_addr = pc_q;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      pc_q    <= RESET_PC;
      out_q   <= 2'd0;
      stale_q <= 2'd0;
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      stale_q <= stale_d;
    end
  end

  // Head/tail buffer; a redirect drops both entries after any same-cycle pop.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      cnt_q  <= 2'd0;
      hd_dat <= 32'd0;
      hd_pc  <= 32'd0;
      tl_dat <= 32'd0;
      tl_pc  <= 32'd0;
    end else if (redir) begin
      cnt_q <= 2'd0;
    end else begin
      case ({pop, rsp_fresh})
        2'b11: begin
          if (cnt_q == 2'd2) begin
            hd_dat <= tl_dat;
            hd_pc  <= tl_pc;
            tl_dat <= imem_rdata;
            tl_pc  <= rsp_pc;
          end else begin
            hd_dat <= imem_rdata;
            hd_pc  <= rsp_pc;
          end
        end
        2'b10: begin
          hd_dat <= tl_dat;
          hd_pc  <= tl_pc;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) begin
            hd_dat <= imem_rdata;
            hd_pc  <= rsp_pc;
          end else begin
            tl_dat <= imem_rdata;
            tl_pc  <= rsp_pc;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign inst_valid = (cnt_q != 2'd0);
  assign inst       = inst_valid ? hd_dat : NOP_INST;
  assign inst_pc    = inst_valid ? hd_pc : 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: memory responder with in-order queue and a scoreboard of
// the instructions the buffer must present, flushed whenever a redirect takes effect.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  if_fetch dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid)
  );

  initial forever #5 cpu_clk = ~cpu_clk;

  typedef struct { logic [31:0] pc; logic [31:0] dat; } exp_t;
  typedef struct { int tag; logic [31:0] addr; } mreq_t;

  exp_t        sb[$];
  mreq_t       mem_q[$];
  logic [31:0] post_g[$];
  logic [31:0] pop_q[$];

  int          total = 0;
  int          bad = 0;
  int          epoch = 0;
  int          cur_tag = -1;
  int          cyc = 0;
  int          first_g = -1;
  int          first_v = -1;
  int          ngrant = 0;
  logic [31:0] cur_addr = 32'd0;
  logic [31:0] last_g = 32'd0;
  bit          resp_en = 1'b1;
  bit          jal_mode = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jal_mode && (a == 32'd0)) return 32'h0080_006F;
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check buffer head against the scoreboard, log grants/responses, advance, respond.
  task automatic tick();
    exp_t  e;
    mreq_t m;
    bit    popped;
    bit    redir_now;
    #1;
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      chk("inst_pc", inst_pc, sb[0].pc);
      chk("inst", inst, sb[0].dat);
    end else begin
      chk("idle_inst_pc", inst_pc, 32'd0);
      chk("idle_inst", inst, NOP);
    end
    popped    = id_ready && (sb.size() != 0);
    redir_now = redirect_valid;
`ifdef IF_JAL_PREDECODE_EN
    if (popped && (sb[0].dat[6:0] == 7'b1101111) && !redirect_valid) redir_now = 1'b1;
`endif
    if (popped) begin
      e = sb.pop_front();
      pop_q.push_back(e.pc);
    end
    if (imem_rvalid && !redir_now && (cur_tag == epoch)) begin
      e.pc  = cur_addr;
      e.dat = mem_word(cur_addr);
      sb.push_back(e);
    end
    if (imem_req && imem_gnt) begin
      m.tag  = epoch;
      m.addr = imem_addr;
      mem_q.push_back(m);
      post_g.push_back(imem_addr);
      last_g = imem_addr;
      ngrant++;
      if (first_g < 0) first_g = cyc;
    end
    if (inst_valid && (first_v < 0)) first_v = cyc;
    if (redir_now) begin
      epoch++;
      sb.delete();
      post_g.delete();
    end
    @(posedge cpu_clk);
    #1;
    if (resp_en && (mem_q.size() != 0)) begin
      m           = mem_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(m.addr);
      cur_addr    = m.addr;
      cur_tag     = m.tag;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    cpu_rst        = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;
    redirect_valid = 1'b0;
    mem_q.delete();
    sb.delete();
    post_g.delete();
    pop_q.delete();
    epoch++;
    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 32'd0);
    cpu_rst = 1'b1;
    cyc     = 0;
    first_g = -1;
    first_v = -1;
    ngrant  = 0;
  endtask

  initial begin
    int g0;
    int n0;
    #3;

    // Streaming with 1-cycle memory and decode always ready
    do_reset();
    repeat (8) tick();
    chk("a_first_grant_cycle", 32'(first_g), 32'd1);
    chk("a_grant_to_valid", 32'(first_v - first_g), 32'd2);
    chk("a_grant0", post_g[0], 32'h0);
    chk("a_grant1", post_g[1], 32'h4);
    chk("a_grant2", post_g[2], 32'h8);
    chk("a_pop0", pop_q[0], 32'h0);
    chk("a_pop1", pop_q[1], 32'h4);
    chk("a_pop2", pop_q[2], 32'h8);

    // Decode stalled: buffer fills to two entries and requests stop
    do_reset();
    id_ready = 1'b0;
    repeat (6) tick();
    #1;
    chk("b_grants", 32'(ngrant), 32'd2);
    chk("b_imem_req", {31'd0, imem_req}, 32'd0);
    chk("b_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("b_inst", inst, mem_word(32'h0));
    chk("b_inst_pc", inst_pc, 32'h0);
    id_ready = 1'b1;
    repeat (6) tick();
    chk("b_pop0", pop_q[0], 32'h0);
    chk("b_pop1", pop_q[1], 32'h4);

    // Redirect with two requests in flight: both responses discarded
    do_reset();
    resp_en = 1'b0;
    repeat (3) tick();
    #1;
    chk("c_outstanding", 32'(ngrant), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    repeat (2) begin
      tick();
      #1;
      chk("c_flush_req", {31'd0, imem_req}, 32'd0);
    end
    resp_en = 1'b1;
    for (int i = 0; (i < 30) && (pop_q.size() == 0); i++) tick();
    chk("c_pop_seen", {31'd0, pop_q.size() != 0}, 32'd1);
    chk("c_first_grant", post_g[0], 32'h0000_0100);
    chk("c_first_pop", pop_q[0], 32'h0000_0100);

    // Address wrap, with a redirect target carrying low bits that must be ignored
    do_reset();
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    n0 = pop_q.size();
    for (int i = 0; (i < 30) && (post_g.size() < 2); i++) tick();
    chk("d_grant_top", post_g[0], 32'hFFFF_FFFC);
    chk("d_grant_wrap", post_g[1], 32'h0);
    for (int i = 0; (i < 30) && (pop_q.size() < n0 + 2); i++) tick();
    chk("d_pop_top", pop_q[n0], 32'hFFFF_FFFC);
    chk("d_pop_wrap", pop_q[n0 + 1], 32'h0);

    // Asynchronous reset mid-stream
    repeat (2) tick();
    #2;
    cpu_rst = 1'b0;
    #1;
    chk("e_async_req", {31'd0, imem_req}, 32'd0);
    chk("e_async_addr", imem_addr, 32'h0);
    chk("e_async_valid", {31'd0, inst_valid}, 32'd0);
    chk("e_async_inst", inst, NOP);
    chk("e_async_pc", inst_pc, 32'd0);
    do_reset();
    for (int i = 0; (i < 10) && (ngrant == 0); i++) tick();
    chk("e_grant_seen", {31'd0, ngrant != 0}, 32'd1);
    chk("e_first_addr", post_g[0], 32'h0);
    chk("e_first_cycle", 32'(first_g), 32'd1);

    // JAL at PC 0
    do_reset();
    jal_mode = 1'b1;
    for (int i = 0; (i < 20) && (pop_q.size() == 0); i++) tick();
    chk("f_jal_pop", pop_q[0], 32'h0);
    g0 = ngrant;
    for (int i = 0; (i < 10) && (ngrant == g0); i++) tick();
    chk("f_next_req", last_g, 32'h8);
    for (int i = 0; (i < 20) && (pop_q.size() < 2); i++) tick();
`ifdef IF_JAL_PREDECODE_EN
    chk("f_second_pop", pop_q[1], 32'h8);
`else
    chk("f_second_pop", pop_q[1], 32'h4);
`endif
    jal_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
